// File: rtl/fifo_wr_framer.sv
// fifo_wr_framer: frames a valid/ready packet stream into async-FIFO writes with a length trailer.
// Define FIFO_WR_FRAMER_CSUM_EN to append an XOR checksum word after the trailer.
`timescale 1ns/1ps
module fifo_wr_framer #(
  parameter int DSIZE   = 8,
  parameter int MAX_LEN = 64
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_last,
  input  logic             wfull,
  input  logic             wthree_quarters_full,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  output logic             trunc,
  output logic [15:0]      pkt_cnt
);
  localparam logic [DSIZE-1:0] MAX = DSIZE'(MAX_LEN);
  typedef enum logic [2:0] {
`ifdef FIFO_WR_FRAMER_CSUM_EN
    CSUM,
`endif
    IDLE,
    DATA,
    DROP,
    TRAIL
  } state_t;
  state_t           r_state, w_nstate;
  logic             r_ov, r_fin, r_drop, r_trunc;
  logic [DSIZE-1:0] r_od, r_len;
  logic [15:0]      r_pkt_cnt;
  logic             w_free, w_xfer, w_load, w_ld_fin, w_drop, w_trunc;
  logic [DSIZE-1:0] w_ld_data, w_len, w_len_inc;
`ifdef FIFO_WR_FRAMER_CSUM_EN
  logic [DSIZE-1:0] r_csum, w_csum;
`endif
  assign w_free    = ~r_ov | ~wfull;
  assign w_xfer    = s_valid & s_ready;
  assign w_len_inc = r_len + 1'b1;
  assign winc      = r_ov & ~wfull;
  assign wdata     = r_od;
  assign trunc     = r_trunc;
  assign pkt_cnt   = r_pkt_cnt;
  always_comb begin
    w_nstate  = r_state;
    s_ready   = 1'b0;
    w_load    = 1'b0;
    w_ld_data = r_od;
    w_ld_fin  = 1'b0;
    w_len     = r_len;
    w_drop    = r_drop;
    w_trunc   = 1'b0;
`ifdef FIFO_WR_FRAMER_CSUM_EN
    w_csum    = r_csum;
`endif
    case (r_state)
      IDLE: begin
        s_ready = w_free & ~wthree_quarters_full;
        if (w_xfer) begin
          w_load    = 1'b1;
          w_ld_data = s_data;
          w_len     = DSIZE'(1);
`ifdef FIFO_WR_FRAMER_CSUM_EN
          w_csum    = s_data;
`endif
          w_nstate  = (s_last || MAX == DSIZE'(1)) ? TRAIL : DATA;
          w_trunc   = ~s_last && MAX == DSIZE'(1);
          w_drop    = w_trunc;
        end
      end
      DATA: begin
        s_ready = w_free;
        if (w_xfer) begin
          w_load    = 1'b1;
          w_ld_data = s_data;
          w_len     = w_len_inc;
`ifdef FIFO_WR_FRAMER_CSUM_EN
          w_csum    = r_csum ^ s_data;
`endif
          // s_last on the MAX_LEN-th word is a normal close, not a truncation
          w_trunc   = ~s_last && w_len_inc == MAX;
          w_drop    = w_trunc;
          w_nstate  = (s_last || w_trunc) ? TRAIL : DATA;
        end
      end
      TRAIL: begin
        if (w_free) begin
          w_load    = 1'b1;
          w_ld_data = r_len;
`ifdef FIFO_WR_FRAMER_CSUM_EN
          w_nstate  = CSUM;
`else
          w_ld_fin  = 1'b1;
          w_nstate  = r_drop ? DROP : IDLE;
`endif
        end
      end
`ifdef FIFO_WR_FRAMER_CSUM_EN
      CSUM: begin
        if (w_free) begin
          w_load    = 1'b1;
          w_ld_data = r_csum;
          w_ld_fin  = 1'b1;
          w_nstate  = r_drop ? DROP : IDLE;
        end
      end
`endif
      DROP: begin
        s_ready = 1'b1;
        if (w_xfer && s_last) begin
          w_drop   = 1'b0;
          w_nstate = IDLE;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state   <= IDLE;
      r_ov      <= 1'b0;
      r_od      <= '0;
      r_fin     <= 1'b0;
      r_len     <= '0;
      r_drop    <= 1'b0;
      r_trunc   <= 1'b0;
      r_pkt_cnt <= '0;
`ifdef FIFO_WR_FRAMER_CSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_state   <= w_nstate;
      r_ov      <= w_load | (r_ov & ~w_free);
      r_od      <= w_load ? w_ld_data : r_od;
      r_fin     <= w_load ? w_ld_fin : r_fin;
      r_len     <= w_len;
      r_drop    <= w_drop;
      r_trunc   <= w_trunc;
      // r_fin marks the word in the output register as the packet's last framing word
      r_pkt_cnt <= r_pkt_cnt + 16'(winc & r_fin);
`ifdef FIFO_WR_FRAMER_CSUM_EN
      r_csum    <= w_csum;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_wr_framer.sv
// tb_fifo_wr_framer: directed bench for fifo_wr_framer with MAX_LEN=4.
`timescale 1ns/1ps
module tb_fifo_wr_framer;
  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       wfull = 1'b0;
  logic       wtqf = 1'b0;
  logic       winc;
  logic [7:0] wdata;
  logic       trunc;
  logic [15:0] pkt_cnt;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int trunc_cnt = 0;
  int lb = 0;
  int t0;
  logic [7:0] log_q[$];
  int         log_t[$];
  logic [7:0] exp_q[$];

  fifo_wr_framer #(.DSIZE(8), .MAX_LEN(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .wfull(wfull),
    .wthree_quarters_full(wtqf), .winc(winc), .wdata(wdata),
    .trunc(trunc), .pkt_cnt(pkt_cnt)
  );

  always #5 wclk = ~wclk;
  always @(posedge wclk) cyc++;
  always @(negedge wclk) begin
    if (winc) begin
      log_q.push_back(wdata);
      log_t.push_back(cyc);
    end
    if (trunc) trunc_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    @(negedge wclk);
    while (!s_ready && n < 50) begin
      @(negedge wclk);
      n++;
    end
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("accept", 32'(n < 50), 1);
  endtask

  task automatic check_log(input string tag, input bit contig);
    chk({tag, "_count"}, 32'(log_q.size() - lb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (lb + i < log_q.size()) begin
        chk({tag, "_word"}, 32'(log_q[lb+i]), 32'(exp_q[i]));
        if (contig) chk({tag, "_consecutive"}, 32'(log_t[lb+i] - log_t[lb]), 32'(i));
      end
    lb = log_q.size();
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_winc", 32'(winc), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("rst_trunc", 32'(trunc), 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    repeat (2) tick();
    wrst_n = 1'b1;
    tick();
    // basic packet, with one-cycle latency check
    send_word(8'h11, 1'b0);
    chk("latency_winc", 32'(winc), 1);
    chk("latency_wdata", 32'(wdata), 32'h11);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b1);
    repeat (6) tick();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h03};
`ifdef FIFO_WR_FRAMER_CSUM_EN
    exp_q.push_back(8'h00);
`endif
    check_log("basic", 1'b1);
    chk("basic_pkt_cnt", 32'(pkt_cnt), 1);
    // backpressure: wfull for 5 cycles after first load
    send_word(8'h11, 1'b0);
    wfull = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge wclk);
      chk("stall_s_ready", 32'(s_ready), 0);
      chk("stall_winc", 32'(winc), 0);
      tick();
    end
    wfull = 1'b0;
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b1);
    repeat (6) tick();
    check_log("backpressure", 1'b0);
    chk("bp_pkt_cnt", 32'(pkt_cnt), 2);
    // truncation at MAX_LEN=4
    t0 = trunc_cnt;
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b0);
    send_word(8'h03, 1'b0);
    send_word(8'h04, 1'b0);
    chk("trunc_pulse", 32'(trunc), 1);
    send_word(8'h05, 1'b0);
    send_word(8'h06, 1'b1);
    repeat (6) tick();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
`ifdef FIFO_WR_FRAMER_CSUM_EN
    exp_q.push_back(8'h04);
`endif
    check_log("trunc", 1'b0);
    chk("trunc_once", 32'(trunc_cnt - t0), 1);
    chk("trunc_pkt_cnt", 32'(pkt_cnt), 3);
    send_word(8'hAA, 1'b0);
    send_word(8'hBB, 1'b1);
    repeat (6) tick();
    exp_q = '{8'hAA, 8'hBB, 8'h02};
`ifdef FIFO_WR_FRAMER_CSUM_EN
    exp_q.push_back(8'h11);
`endif
    check_log("after_trunc", 1'b1);
    chk("after_trunc_pkt_cnt", 32'(pkt_cnt), 4);
    // exact-length packet: no trunc, no drop
    t0 = trunc_cnt;
    send_word(8'h0A, 1'b0);
    send_word(8'h0B, 1'b0);
    send_word(8'h0C, 1'b0);
    send_word(8'h0D, 1'b1);
    send_word(8'h77, 1'b1);
    repeat (8) tick();
    exp_q = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h04};
`ifdef FIFO_WR_FRAMER_CSUM_EN
    exp_q.push_back(8'h00);
`endif
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h01);
`ifdef FIFO_WR_FRAMER_CSUM_EN
    exp_q.push_back(8'h77);
`endif
    check_log("exact", 1'b1);
    chk("exact_no_trunc", 32'(trunc_cnt - t0), 0);
    chk("exact_pkt_cnt", 32'(pkt_cnt), 6);
    // throttle gates only the first word
    wtqf = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk);
      chk("throttle_s_ready", 32'(s_ready), 0);
      tick();
    end
    wtqf = 1'b0;
    #1;
    chk("throttle_release", 32'(s_ready), 1);
    send_word(8'h55, 1'b0);
    wtqf = 1'b1;
    #1;
    chk("throttle_midpkt", 32'(s_ready), 1);
    send_word(8'h66, 1'b1);
    wtqf = 1'b0;
    repeat (6) tick();
    exp_q = '{8'h55, 8'h66, 8'h02};
`ifdef FIFO_WR_FRAMER_CSUM_EN
    exp_q.push_back(8'h33);
`endif
    check_log("throttle", 1'b1);
    chk("throttle_pkt_cnt", 32'(pkt_cnt), 7);
    // reset mid-packet
    send_word(8'h21, 1'b0);
    send_word(8'h22, 1'b0);
    wrst_n = 1'b0;
    #1;
    chk("midrst_winc", 32'(winc), 0);
    chk("midrst_wdata", 32'(wdata), 0);
    chk("midrst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("midrst_s_ready", 32'(s_ready), 1);
    @(negedge wclk);
    wrst_n = 1'b1;
    tick();
    exp_q = '{8'h21};
    check_log("midrst_partial", 1'b0);
    send_word(8'h31, 1'b0);
    send_word(8'h32, 1'b1);
    repeat (6) tick();
    exp_q = '{8'h31, 8'h32, 8'h02};
`ifdef FIFO_WR_FRAMER_CSUM_EN
    exp_q.push_back(8'h03);
`endif
    check_log("post_rst", 1'b1);
    chk("post_rst_pkt_cnt", 32'(pkt_cnt), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
